snooze_countdown: RTL and testbench

//  Countdown (decrementing) BCD timer for the alarm clock's snooze function: the borrow-chain

---
 rtl/snooze_countdown.sv | 103 ++++++++++
 tb/tb_snooze_countdown.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/snooze_countdown.sv
// Snooze countdown timer: loads M:00 and counts down in BCD once per prescaled tick.
// A three-state FSM (IDLE/RUN/DONE) flags expiry with a one-cycle registered pulse.
module snooze_countdown #(
    parameter int TICK_DIV = 50_000_000,
    parameter int PRE_W    = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cancel,
    input  logic [3:0] load_min,
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [1:0]       state, state_nx;
    logic [PRE_W-1:0] pre, pre_nx;
    logic [3:0]       min_nx, tens_nx, ones_nx;
    logic [3:0]       load_clamped;
    logic             borrow_ones, borrow_tens;

    assign load_clamped = (load_min > 4'd9) ? 4'd9 : load_min;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nx    = state;
        pre_nx      = pre;
        min_nx      = min;
        tens_nx     = sec_tens;
        ones_nx     = sec_ones;
        borrow_ones = 1'b0;
        borrow_tens = 1'b0;

        if (cancel) begin
            state_nx = IDLE;
            pre_nx   = '0;
            min_nx   = 4'd0;
            tens_nx  = 4'd0;
            ones_nx  = 4'd0;
        end else if (start) begin
            // Reload wins over any tick on the same edge.
            state_nx = (load_clamped == 4'd0) ? DONE : RUN;
            pre_nx   = '0;
            min_nx   = load_clamped;
            tens_nx  = 4'd0;
            ones_nx  = 4'd0;
        end else if (state == RUN) begin
            if (pre == PRE_LAST) begin
                pre_nx      = '0;
                borrow_ones = (sec_ones == 4'd0);
                ones_nx     = borrow_ones ? 4'd9 : sec_ones - 4'd1;
                if (borrow_ones) begin
                    borrow_tens = (sec_tens == 4'd0);
                    tens_nx     = borrow_tens ? 4'd5 : sec_tens - 4'd1;
                    if (borrow_tens) begin
                        min_nx = min - 4'd1;
                    end
                end
                // RUN never holds 0:00, so reaching it here is the expiry edge.
                if (min_nx == 4'd0 && tens_nx == 4'd0 && ones_nx == 4'd0) begin
                    state_nx = DONE;
                end
            end else begin
                pre_nx = pre + PRE_W'(1);
            end
        end
    end

    // Status outputs are registered from the next state so they come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pre      <= '0;
            min      <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            running  <= 1'b0;
            done     <= 1'b0;
            expired  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state    <= state_nx;
            pre      <= pre_nx;
            min      <= min_nx;
            sec_tens <= tens_nx;
            sec_ones <= ones_nx;
            running  <= (state_nx == RUN);
            done     <= (state_nx == DONE);
            expired  <= (state_nx == DONE) && (state != DONE);
        end
    end

endmodule

// File: tb/tb_snooze_countdown.sv
// Directed bench for snooze_countdown with TICK_DIV=4; digits compared as 12'hMST.
module tb_snooze_countdown;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       cancel;
    logic [3:0] load_min;
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       done;
    logic       expired;

    int n_checks;
    int n_pass;
    int exp_count;
    bit bcd_ok;

    snooze_countdown #(.TICK_DIV(4), .PRE_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cancel   (cancel),
        .load_min (load_min),
        .min      (min),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .done     (done),
        .expired  (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] digits();
        return {min, sec_tens, sec_ones};
    endfunction

    // Advance n clock edges; inputs change and outputs are sampled on the falling edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if (sec_tens > 4'd5 || sec_ones > 4'd9 || min > 4'd9) bcd_ok = 1'b0;
            if (expired) exp_count++;
        end
    endtask

    task automatic pulse_start(input logic [3:0] m);
        load_min = m;
        start    = 1'b1;
        cycles(1);
        start    = 1'b0;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1;
        cycles(1);
        cancel = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bcd_ok   = 1'b1;
        rst_n    = 1'b0;
        start    = 1'b0;
        cancel   = 1'b0;
        load_min = 4'd0;
        #17 rst_n = 1'b1;
        @(negedge clk);
        check("reset_digits", digits(), 12'h000);
        check("reset_flags", {running, done, expired}, 3'b000);

        // 1: one minute down to zero
        pulse_start(4'd1);
        check("t1_load", digits(), 12'h100);
        check("t1_running", running, 1'b1);
        cycles(3);
        check("t1_pre_tick", digits(), 12'h100);
        cycles(1);
        check("t1_borrow", digits(), 12'h059);
        cycles(235);
        check("t1_last_sec", digits(), 12'h001);
        exp_count = 0;
        cycles(1);
        check("t1_zero", digits(), 12'h000);
        check("t1_flags", {running, done, expired}, 3'b011);
        cycles(1);
        check("t1_exp_once", {done, expired}, 2'b10);
        pulse_cancel();

        // 2: zero load goes straight to DONE
        exp_count = 0;
        pulse_start(4'd0);
        check("t2_flags", {running, done, expired}, 3'b011);
        check("t2_digits", digits(), 12'h000);
        cycles(1);
        check("t2_exp_count", exp_count, 1);
        pulse_cancel();

        // 3: clamp 12 -> 9, borrow through sec_tens
        bcd_ok = 1'b1;
        pulse_start(4'hC);
        check("t3_clamp", digits(), 12'h900);
        load_min = 4'd2;
        cycles(4);
        check("t3_first", digits(), 12'h859);
        cycles(4);
        check("t3_second", digits(), 12'h858);

        // 4: cancel beats start; start alone reloads
        cycles(84);
        check("t4_at_837", digits(), 12'h837);
        exp_count = 0;
        cancel = 1'b1;
        start  = 1'b1;
        cycles(1);
        cancel = 1'b0;
        start  = 1'b0;
        check("t4_cancel_digits", digits(), 12'h000);
        check("t4_cancel_flags", {running, done, exp_count[0]}, 3'b000);
        pulse_start(4'd9);
        cycles(92);
        check("t4_again_837", digits(), 12'h837);
        pulse_start(4'd9);
        check("t4_reload", digits(), 12'h900);
        cycles(3);
        check("t4_hold", digits(), 12'h900);
        cycles(1);
        check("t4_next_dec", digits(), 12'h859);
        check("t3_bcd", bcd_ok, 1'b1);
        pulse_cancel();

        // 5: DONE holds, expired pulses once
        exp_count = 0;
        pulse_start(4'd0);
        cycles(5);
        check("t5_done_hold", {done, running, expired}, 3'b100);
        check("t5_exp_count", exp_count, 1);
        pulse_cancel();
        check("t5_cancel", {done, running}, 2'b00);

        // 6: async reset mid-run
        pulse_start(4'd4);
        cycles(156);
        check("t6_at_321", digits(), 12'h321);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_digits", digits(), 12'h000);
        check("t6_async_flags", {running, done, expired}, 3'b000);
        cycles(2);
        rst_n = 1'b1;
        cycles(6);
        check("t6_idle_after", {digits(), running, done}, 14'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
